// File: rtl/smaqa_pkg.sv
// Shared types, slot constants and helpers for the SMAQA operand collector.
package smaqa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } opcoll_state_e;

    typedef enum logic [0:0] {
        SMAQA   = 1'b0,
        SMAQA64 = 1'b1
    } fu_op;

    localparam int SMAQA_MAX_OPS = 5;

    localparam logic [2:0] SLOT_A = 3'd0;
    localparam logic [2:0] SLOT_B = 3'd1;
    localparam logic [2:0] SLOT_C = 3'd2;
    localparam logic [2:0] SLOT_D = 3'd3;
    localparam logic [2:0] SLOT_E = 3'd4;

    function automatic logic [2:0] smaqa_nr_ops(fu_op op);
        return (op == SMAQA64) ? 3'd5 : 3'd3;
    endfunction

    // Register index feeding a slot; the +1 forms wrap naturally in 5 bits.
    function automatic logic [4:0] smaqa_slot_addr(logic [2:0] slot, logic [4:0] rs1,
                                                   logic [4:0] rs2, logic [4:0] rd);
        case (slot)
            SLOT_A:  return rs1;
            SLOT_B:  return rs2;
            SLOT_C:  return rd;
            SLOT_D:  return rs1 + 5'd1;
            default: return rs2 + 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/smaqa_operand_collector_if.sv
// Issue, regfile read, writeback snoop and multiplier bundle of the operand collector.
// Handshakes (issue and mult): a transfer occurs on a rising edge where valid and ready are
// both high; the multiplier-side payload holds stable from valid rising until that transfer.
interface smaqa_operand_collector_if #(
    parameter int NR_RD_PORTS   = 2,
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 3
);
    import smaqa_pkg::*;

    logic                                issue_valid_i;
    logic                                issue_ready_o;
    fu_op                                issue_op_i;
    logic [4:0]                          issue_rs1_i;
    logic [4:0]                          issue_rs2_i;
    logic [4:0]                          issue_rd_i;
    logic [TRANS_ID_BITS-1:0]            issue_trans_id_i;

    logic [NR_RD_PORTS-1:0][4:0]         rf_raddr_o;
    logic [NR_RD_PORTS-1:0][XLEN-1:0]    rf_rdata_i;

    logic                                wb_we_i;
    logic [4:0]                          wb_waddr_i;
    logic [XLEN-1:0]                     wb_wdata_i;

    logic                                mult_valid_o;
    logic                                mult_ready_i;
    fu_op                                mult_op_o;
    logic [XLEN-1:0]                     mult_operand_a_o;
    logic [XLEN-1:0]                     mult_operand_b_o;
    logic [XLEN-1:0]                     mult_operand_c_o;
    logic [XLEN-1:0]                     mult_operand_d_o;
    logic [XLEN-1:0]                     mult_operand_e_o;
    logic [TRANS_ID_BITS-1:0]            mult_trans_id_o;

    modport slave (
        input  issue_valid_i, issue_op_i, issue_rs1_i, issue_rs2_i, issue_rd_i,
               issue_trans_id_i, rf_rdata_i, wb_we_i, wb_waddr_i, wb_wdata_i, mult_ready_i,
        output issue_ready_o, rf_raddr_o, mult_valid_o, mult_op_o, mult_operand_a_o,
               mult_operand_b_o, mult_operand_c_o, mult_operand_d_o, mult_operand_e_o,
               mult_trans_id_o
    );

    modport master (
        output issue_valid_i, issue_op_i, issue_rs1_i, issue_rs2_i, issue_rd_i,
               issue_trans_id_i, rf_rdata_i, wb_we_i, wb_waddr_i, wb_wdata_i, mult_ready_i,
        input  issue_ready_o, rf_raddr_o, mult_valid_o, mult_op_o, mult_operand_a_o,
               mult_operand_b_o, mult_operand_c_o, mult_operand_d_o, mult_operand_e_o,
               mult_trans_id_o
    );

endinterface

// File: rtl/smaqa_addr_gen.sv
// Maps the current read group onto regfile port addresses, slot numbers and a port-valid mask.
module smaqa_addr_gen
    import smaqa_pkg::*;
#(
    parameter int NR_RD_PORTS = 2
) (
    input  logic [4:0]                  rs1,
    input  logic [4:0]                  rs2,
    input  logic [4:0]                  rd,
    input  logic [2:0]                  grp,
    input  logic [2:0]                  nr_ops,
    output logic [NR_RD_PORTS-1:0][4:0] raddr,
    output logic [NR_RD_PORTS-1:0]      port_valid,
    output logic [NR_RD_PORTS-1:0][2:0] port_slot
);

    always_comb begin
        raddr      = '0;
        port_valid = '0;
        port_slot  = '0;
        for (int p = 0; p < NR_RD_PORTS; p++) begin
            // Slot s lives in group s/NR_RD_PORTS on port s%NR_RD_PORTS.
            if (int'(grp) * NR_RD_PORTS + p < int'(nr_ops)) begin
                port_valid[p] = 1'b1;
                port_slot[p]  = 3'(int'(grp) * NR_RD_PORTS + p);
                raddr[p]      = smaqa_slot_addr(3'(int'(grp) * NR_RD_PORTS + p), rs1, rs2, rd);
            end
        end
    end

endmodule

// File: rtl/smaqa_operand_collector.sv
// Collects up to five SMAQA operands over NR_RD_PORTS regfile ports and hands them to the multiplier.
// Optional writeback forwarding during collection is enabled with SMAQA_OPCOLL_FWD_EN.
module smaqa_operand_collector
    import smaqa_pkg::*;
#(
    parameter int NR_RD_PORTS   = 2,
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    smaqa_operand_collector_if.slave   bus,
    output opcoll_state_e              dbg_state
);

`ifdef SMAQA_OPCOLL_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    opcoll_state_e            state_q, state_d;
    fu_op                     op_q;
    logic [4:0]               rs1_q, rs2_q, rd_q;
    logic [TRANS_ID_BITS-1:0] id_q;
    logic [2:0]               grp_q, grp_d;
    logic [XLEN-1:0]          opnd_q [SMAQA_MAX_OPS];
    logic [XLEN-1:0]          opnd_d [SMAQA_MAX_OPS];
    logic                     accept;
    logic                     last_grp;
    logic                     fwd_hit;
    logic [2:0]               nr_ops;

    logic [NR_RD_PORTS-1:0][4:0] gen_raddr;
    logic [NR_RD_PORTS-1:0]      port_valid;
    logic [NR_RD_PORTS-1:0][2:0] port_slot;

    assign nr_ops   = smaqa_nr_ops(op_q);
    assign last_grp = (int'(grp_q) + 1) * NR_RD_PORTS >= int'(nr_ops);
    assign fwd_hit  = FWD_EN && bus.wb_we_i && (bus.wb_waddr_i != 5'd0);

    smaqa_addr_gen #(
        .NR_RD_PORTS(NR_RD_PORTS)
    ) u_addr_gen (
        .rs1       (rs1_q),
        .rs2       (rs2_q),
        .rd        (rd_q),
        .grp       (grp_q),
        .nr_ops    (nr_ops),
        .raddr     (gen_raddr),
        .port_valid(port_valid),
        .port_slot (port_slot)
    );

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        accept  = 1'b0;
        opnd_d  = opnd_q;
        case (state_q)
            IDLE: begin
                if (bus.issue_valid_i && !flush_i) begin
                    accept  = 1'b1;
                    state_d = COLLECT;
                    grp_d   = 3'd0;
                    for (int s = 0; s < SMAQA_MAX_OPS; s++) opnd_d[s] = '0;
                end
            end
            COLLECT: begin
                grp_d = grp_q + 3'd1;
                if (last_grp) state_d = ISSUE;
                // A write to a slot captured in an earlier group keeps it coherent.
                for (int s = 0; s < SMAQA_MAX_OPS; s++) begin
                    if (fwd_hit && s < int'(grp_q) * NR_RD_PORTS &&
                        smaqa_slot_addr(3'(s), rs1_q, rs2_q, rd_q) == bus.wb_waddr_i)
                        opnd_d[s] = bus.wb_wdata_i;
                end
                for (int p = 0; p < NR_RD_PORTS; p++) begin
                    if (port_valid[p]) begin
                        if (gen_raddr[p] == 5'd0)
                            opnd_d[port_slot[p]] = '0;
                        else if (fwd_hit && gen_raddr[p] == bus.wb_waddr_i)
                            opnd_d[port_slot[p]] = bus.wb_wdata_i;
                        else
                            opnd_d[port_slot[p]] = bus.rf_rdata_i[p];
                    end
                end
            end
            ISSUE: begin
                if (bus.mult_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= SMAQA;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            id_q    <= '0;
            grp_q   <= '0;
            for (int s = 0; s < SMAQA_MAX_OPS; s++) opnd_q[s] <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            opnd_q  <= opnd_d;
            if (accept) begin
                op_q  <= bus.issue_op_i;
                rs1_q <= bus.issue_rs1_i;
                rs2_q <= bus.issue_rs2_i;
                rd_q  <= bus.issue_rd_i;
                id_q  <= bus.issue_trans_id_i;
            end
        end
    end

    assign bus.issue_ready_o    = (state_q == IDLE);
    assign bus.mult_valid_o     = (state_q == ISSUE);
    assign bus.rf_raddr_o       = (state_q == COLLECT) ? gen_raddr : '0;
    assign bus.mult_op_o        = op_q;
    assign bus.mult_trans_id_o  = id_q;
    assign bus.mult_operand_a_o = opnd_q[SLOT_A];
    assign bus.mult_operand_b_o = opnd_q[SLOT_B];
    assign bus.mult_operand_c_o = opnd_q[SLOT_C];
    assign bus.mult_operand_d_o = opnd_q[SLOT_D];
    assign bus.mult_operand_e_o = opnd_q[SLOT_E];
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_smaqa_operand_collector.sv
// Bench for smaqa_operand_collector: directed vector table, flush corners and randomized transactions.
module tb_smaqa_operand_collector;
    import smaqa_pkg::*;

    localparam int P    = 2;
    localparam int XLEN = 32;
    localparam int TID  = 3;

    typedef logic [31:0] opnd_arr_t [5];

    typedef struct {
        fu_op       op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] id;
        logic [31:0] a, b, c, d, e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    opcoll_state_e dbg_state;
    logic [31:0] rf_mem [32];
    int n_pass = 0;
    int n_total = 0;

    smaqa_operand_collector_if #(.NR_RD_PORTS(P), .XLEN(XLEN), .TRANS_ID_BITS(TID)) bus ();

    smaqa_operand_collector #(.NR_RD_PORTS(P), .XLEN(XLEN), .TRANS_ID_BITS(TID)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (flush),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Combinational regfile model; x0 deliberately holds garbage.
    always_comb begin
        for (int p = 0; p < P; p++) bus.rf_rdata_i[p] = rf_mem[bus.rf_raddr_o[p]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [4:0] addr_m(int s, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
        case (s)
            0: return rs1;
            1: return rs2;
            2: return rd;
            3: return 5'((int'(rs1) + 1) % 32);
            default: return 5'((int'(rs2) + 1) % 32);
        endcase
    endfunction

    function automatic logic [31:0] val_m(logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : rf_mem[a];
    endfunction

    task automatic drive_issue(input fu_op op, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [2:0] id);
        @(negedge clk);
        bus.issue_valid_i    = 1'b1;
        bus.issue_op_i       = op;
        bus.issue_rs1_i      = rs1;
        bus.issue_rs2_i      = rs2;
        bus.issue_rd_i       = rd;
        bus.issue_trans_id_i = id;
        @(posedge clk);
        #1;
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic run_txn(input string tag, input fu_op op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [2:0] id,
                           input opnd_arr_t exp, input int bp, input int fwd_grp,
                           input logic [4:0] fwd_addr, input logic [31:0] fwd_data);
        int n, g, k;
        logic [P-1:0][4:0] er;
        logic [159:0] exp_cat;
        n = (op == SMAQA64) ? 5 : 3;
        g = (n + P - 1) / P;
        exp_cat = {exp[0], exp[1], exp[2], exp[3], exp[4]};
        drive_issue(op, rs1, rs2, rd, id);
        check({tag, " busy"}, bus.issue_ready_o, 0);
        k = 0;
        while (!bus.mult_valid_o && k < 12) begin
            for (int p = 0; p < P; p++)
                er[p] = (k * P + p < n) ? addr_m(k * P + p, rs1, rs2, rd) : 5'd0;
            check($sformatf("%s raddr g%0d", tag, k), bus.rf_raddr_o, er);
            if (k == fwd_grp) begin
                bus.wb_we_i    = 1'b1;
                bus.wb_waddr_i = fwd_addr;
                bus.wb_wdata_i = fwd_data;
            end
            @(posedge clk);
            #1;
            bus.wb_we_i = 1'b0;
            k++;
        end
        check({tag, " latency"}, k, g);
        check({tag, " op"}, bus.mult_op_o, op);
        check({tag, " id"}, bus.mult_trans_id_o, id);
        check({tag, " a"}, bus.mult_operand_a_o, exp[0]);
        check({tag, " b"}, bus.mult_operand_b_o, exp[1]);
        check({tag, " c"}, bus.mult_operand_c_o, exp[2]);
        check({tag, " d"}, bus.mult_operand_d_o, exp[3]);
        check({tag, " e"}, bus.mult_operand_e_o, exp[4]);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, {bus.mult_valid_o, bus.issue_ready_o}, 2'b10);
            check({tag, " hold data"},
                  {bus.mult_operand_a_o, bus.mult_operand_b_o, bus.mult_operand_c_o,
                   bus.mult_operand_d_o, bus.mult_operand_e_o} == exp_cat, 1);
        end
        bus.mult_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.mult_ready_i = 1'b0;
        check({tag, " done"}, {bus.mult_valid_o, bus.issue_ready_o}, 2'b01);
    endtask

    vec_t vecs[5];
    opnd_arr_t ex;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.issue_valid_i = 1'b0;
        bus.issue_op_i = SMAQA;
        bus.issue_rs1_i = '0;
        bus.issue_rs2_i = '0;
        bus.issue_rd_i = '0;
        bus.issue_trans_id_i = '0;
        bus.wb_we_i = 1'b0;
        bus.wb_waddr_i = '0;
        bus.wb_wdata_i = '0;
        bus.mult_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + i;
        rf_mem[0] = 32'hDEAD_BEEF;
        rf_mem[1] = 32'h0102_0304;
        rf_mem[2] = 32'h0;
        rf_mem[3] = 32'h9;
        rf_mem[4] = 32'h0506_0708;
        rf_mem[5] = 32'h0;

        vecs[0] = '{SMAQA,   5'd1,  5'd4,  5'd3, 3'd1, 32'h01020304, 32'h05060708, 32'h9, 32'h0, 32'h0};
        vecs[1] = '{SMAQA64, 5'd1,  5'd4,  5'd3, 3'd2, 32'h01020304, 32'h05060708, 32'h9, 32'h0, 32'h0};
        vecs[2] = '{SMAQA64, 5'd31, 5'd4,  5'd3, 3'd3, 32'h1000001F, 32'h05060708, 32'h9, 32'h0, 32'h0};
        vecs[3] = '{SMAQA64, 5'd0,  5'd30, 5'd1, 3'd4, 32'h0, 32'h1000001E, 32'h01020304, 32'h01020304, 32'h1000001F};
        vecs[4] = '{SMAQA,   5'd6,  5'd7,  5'd0, 3'd5, 32'h10000006, 32'h10000007, 32'h0, 32'h0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        check("reset state", dbg_state, IDLE);
        check("reset handshake", {bus.issue_ready_o, bus.mult_valid_o}, 2'b10);
        check("reset raddr", bus.rf_raddr_o, 0);
        check("reset payload", {bus.mult_op_o, bus.mult_trans_id_o, bus.mult_operand_a_o,
              bus.mult_operand_c_o, bus.mult_operand_e_o} == '0, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post reset ready", bus.issue_ready_o, 1);

        for (int i = 0; i < 5; i++) begin
            ex = '{vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].e};
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                    vecs[i].id, ex, (i == 1) ? 5 : 0, -1, 5'd0, 32'h0);
        end

        // Flush in the second COLLECT cycle.
        drive_issue(SMAQA64, 5'd1, 5'd4, 5'd3, 3'd6);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush collect state", dbg_state, IDLE);
        check("flush collect hs", {bus.issue_ready_o, bus.mult_valid_o}, 2'b10);
        begin
            int seen = 0;
            repeat (6) begin
                @(posedge clk);
                #1;
                seen += int'(bus.mult_valid_o);
            end
            check("flush no valid", seen, 0);
        end
        ex = '{32'h01020304, 32'h05060708, 32'h9, 32'h0, 32'h0};
        run_txn("after flush", SMAQA64, 5'd1, 5'd4, 5'd3, 3'd7, ex, 1, -1, 5'd0, 32'h0);

        // Issue coincident with flush in IDLE is dropped.
        @(negedge clk);
        bus.issue_valid_i = 1'b1;
        bus.issue_op_i = SMAQA;
        flush = 1'b1;
        @(posedge clk);
        #1;
        bus.issue_valid_i = 1'b0;
        flush = 1'b0;
        check("issue+flush dropped", dbg_state, IDLE);
        repeat (3) @(posedge clk);
        #1;
        check("issue+flush no valid", bus.mult_valid_o, 0);

        // Flush in ISSUE together with ready.
        drive_issue(SMAQA, 5'd1, 5'd4, 5'd3, 3'd2);
        begin
            int k = 0;
            while (!bus.mult_valid_o && k < 12) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("flush issue reach", bus.mult_valid_o, 1);
        end
        flush = 1'b1;
        bus.mult_ready_i = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.mult_ready_i = 1'b0;
        check("flush issue state", {bus.issue_ready_o, bus.mult_valid_o}, 2'b10);

        // Writeback to rd while slot c is read, then to rs1 after slot a was captured.
`ifdef SMAQA_OPCOLL_FWD_EN
        ex = '{32'h01020304, 32'h05060708, 32'h77, 32'h0, 32'h0};
`else
        ex = '{32'h01020304, 32'h05060708, 32'h9, 32'h0, 32'h0};
`endif
        run_txn("fwd live", SMAQA, 5'd1, 5'd4, 5'd3, 3'd1, ex, 0, 1, 5'd3, 32'h77);
`ifdef SMAQA_OPCOLL_FWD_EN
        ex = '{32'h55, 32'h05060708, 32'h9, 32'h0, 32'h0};
`else
        ex = '{32'h01020304, 32'h05060708, 32'h9, 32'h0, 32'h0};
`endif
        run_txn("fwd captured", SMAQA, 5'd1, 5'd4, 5'd3, 3'd1, ex, 0, 1, 5'd1, 32'h55);

        // Randomized transactions against the slot/address model.
        for (int t = 0; t < 25; t++) begin
            fu_op op;
            logic [4:0] rs1, rs2, rd;
            int n;
            for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
            op  = fu_op'($urandom_range(0, 1));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            n   = (op == SMAQA64) ? 5 : 3;
            for (int s = 0; s < 5; s++) ex[s] = (s < n) ? val_m(addr_m(s, rs1, rs2, rd)) : 32'h0;
            run_txn($sformatf("rand%0d", t), op, rs1, rs2, rd, 3'($urandom_range(0, 7)), ex,
                    $urandom_range(0, 2), -1, 5'd0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
